// File: rtl/btb_controller_if.sv
// Bundle of fetch, update and BTB file signals for btb_controller.
// slave = controller side, master = fetch/EX/file side.
interface btb_controller_if #(parameter int STAT_W = 16);
  logic [31:0]       pc_if;
  logic [2:0]        read_index;
  logic [127:0]      read_set;
  logic              predict_taken;
  logic [31:0]       predict_target;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic [31:0]       upd_target;
  logic              upd_taken;
  logic              upd_pred_taken;
  logic [31:0]       upd_pred_target;
  logic [2:0]        update_index;
  logic [127:0]      update_set;
  logic [2:0]        write_index;
  logic [127:0]      write_set;
  logic              write_en;
  logic              clearing;
  logic [STAT_W-1:0] stat_updates;
  logic [STAT_W-1:0] stat_mispredicts;

  modport slave (
    input  pc_if, read_set, upd_valid, upd_pc, upd_target, upd_taken,
           upd_pred_taken, upd_pred_target, update_set,
    output read_index, predict_taken, predict_target, update_index,
           write_index, write_set, write_en, clearing, stat_updates,
           stat_mispredicts
  );

  modport master (
    output pc_if, read_set, upd_valid, upd_pc, upd_target, upd_taken,
           upd_pred_taken, upd_pred_target, update_set,
    input  read_index, predict_taken, predict_target, update_index,
           write_index, write_set, write_en, clearing, stat_updates,
           stat_mispredicts
  );
endinterface

// File: rtl/btb_controller.sv
// Lookup and read-modify-write control for an 8-set, 2-way BTB register file.
// Prediction is combinational; an update is captured at one edge and written at the next.
// No backpressure: one update per cycle is accepted, updates arriving during the clear sweep are dropped.
module btb_controller #(
  parameter int STAT_W = 16
) (
  input logic           clk,
  input logic           rst,
  btb_controller_if.slave bus
);

  typedef enum logic [1:0] {CLEAR, IDLE, WRITE} state_t;

  state_t            state;
  logic [2:0]        clr_cnt;
  logic [31:0]       pend_pc;
  logic [31:0]       pend_target;
  logic              pend_taken;
  logic [127:0]      set_hold;
  logic [STAT_W-1:0] n_upd;
  logic [STAT_W-1:0] n_mis;

  // Fetch-side lookup
  logic [63:0] rw0, rw1, rsel;
  logic        rhit0, rhit1;

  assign rw0   = bus.read_set[63:0];
  assign rw1   = bus.read_set[127:64];
  assign rhit0 = rw0[63] && (rw0[62:36] == bus.pc_if[31:5]);
  assign rhit1 = rw1[63] && (rw1[62:36] == bus.pc_if[31:5]);
  assign rsel  = rhit0 ? rw0 : rw1;

  assign bus.read_index     = bus.pc_if[4:2];
  assign bus.predict_taken  = (state != CLEAR) && (rhit0 || rhit1) && rsel[1];
  assign bus.predict_target = bus.predict_taken ? rsel[35:4] : bus.pc_if + 32'd4;

  // Execute-side read-modify-write of the pending set
  logic [63:0]  uw0, uw1, hw, nw;
  logic         uhit0, uhit1, hway, victim, lru_new;
  logic [127:0] rmw_set;
  logic         rmw_changes;

  assign uw0   = bus.update_set[63:0];
  assign uw1   = bus.update_set[127:64];
  assign uhit0 = uw0[63] && (uw0[62:36] == pend_pc[31:5]);
  assign uhit1 = uw1[63] && (uw1[62:36] == pend_pc[31:5]);
  assign hway  = ~uhit0;
  assign hw    = uhit0 ? uw0 : uw1;

  // Build the new set: touched way gets its new contents, LRU bit lives at set bit 2
  always_comb begin
    rmw_set = bus.update_set;
    nw      = '0;
    victim  = 1'b0;
    lru_new = bus.update_set[2];
    if (uhit0 || uhit1) begin
      nw      = hw;
      nw[3:2] = 2'b00;
      if (pend_taken) begin
        nw[35:4] = pend_target;
        if (hw[1:0] != 2'd3) nw[1:0] = hw[1:0] + 2'd1;
      end else if (hw[1:0] != 2'd0) begin
        nw[1:0] = hw[1:0] - 2'd1;
      end
      victim  = hway;
      lru_new = ~hway;
    end else if (pend_taken) begin
      nw = {1'b1, pend_pc[31:5], pend_target, 2'b00, 2'b10};
      if (!uw0[63])      victim = 1'b0;
      else if (!uw1[63]) victim = 1'b1;
      else               victim = bus.update_set[2];
      lru_new = ~victim;
    end
    if (uhit0 || uhit1 || pend_taken) begin
      if (victim) rmw_set[127:64] = nw;
      else        rmw_set[63:0]   = nw;
      rmw_set[2] = lru_new;
    end
  end

  assign rmw_changes = (rmw_set != bus.update_set);

  // File port drive; rst gates the write so a dropped update never commits
  assign bus.update_index = (state == WRITE) ? pend_pc[4:2] : 3'd0;
  assign bus.write_index  = (state == CLEAR) ? clr_cnt :
                            (state == WRITE) ? pend_pc[4:2] : 3'd0;
  assign bus.write_en     = !rst && ((state == CLEAR) || ((state == WRITE) && rmw_changes));
  assign bus.write_set    = (state == CLEAR) ? 128'd0 :
                            (state == WRITE) ? rmw_set : set_hold;
  assign bus.clearing         = (state == CLEAR);
  assign bus.stat_updates     = n_upd;
  assign bus.stat_mispredicts = n_mis;

  logic upd_mis;
  assign upd_mis = (bus.upd_pred_taken != bus.upd_taken) ||
                   (bus.upd_taken && (bus.upd_pred_target != bus.upd_target));

  // State machine: clear sweep, update capture, statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clr_cnt     <= 3'd0;
      pend_pc     <= 32'd0;
      pend_target <= 32'd0;
      pend_taken  <= 1'b0;
      set_hold    <= 128'd0;
      n_upd       <= '0;
      n_mis       <= '0;
    end else begin
      if (state == WRITE) set_hold <= rmw_set;
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 3'd1;
          if (clr_cnt == 3'd7) state <= IDLE;
        end
        default: begin
          if (bus.upd_valid) begin
            pend_pc     <= bus.upd_pc;
            pend_target <= bus.upd_target;
            pend_taken  <= bus.upd_taken;
            state       <= WRITE;
            if (n_upd != '1) n_upd <= n_upd + 1'b1;
            if (upd_mis && (n_mis != '1)) n_mis <= n_mis + 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
